// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and constants for the SPI responder.
// Used by spi_sync and spi_slave.
package spi_pkg;

    localparam int SYNC_STAGES        = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } spi_state_e;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop pin synchronizer with a delayed level and
// registered rise/fall pulses.
module spi_sync
    import spi_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;

    // The data path is left free-running so the level is valid during reset.
    always_ff @(posedge clk) begin
        chain <= {chain[STAGES-2:0], d};
        lvl   <= chain[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= chain[STAGES-1] & ~lvl;
            fall <= ~chain[STAGES-1] & lvl;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 MSB-first responder with a one-word tx buffer.
// Define SPI_SLAVE_OVERRUN_EN to build the sticky overrun detector.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_empty,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  new_data,
    input  logic                  rd_ack,
    output logic                  busy,
    output logic                  overrun
);

    localparam int CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACTIVE = ACTIVE;
    localparam logic [1:0] S_WAIT   = WAIT;

    logic [1:0] state;

    logic sck_rise;
    logic sck_fall;
    logic sck_lvl_unused;
    logic cs_rise;
    logic cs_fall;
    logic cs_lvl;

    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic [DATA_WIDTH-1:0] tx_fill;

    logic active;
    logic enter;
    logic shift_ok;
    logic word_done;
    logic reload;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sck),
        .lvl  (sck_lvl_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n),
        .lvl  (cs_lvl),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk) begin
        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    assign active    = (state == S_ACTIVE);
    assign enter     = (state == S_IDLE) && cs_fall;
    assign shift_ok  = active && !cs_rise;
    assign word_done = shift_ok && sck_rise && (bit_cnt == LAST);
    assign reload    = enter || (shift_ok && sck_fall && (bit_cnt == '0));
    assign rx_next   = {rx_shift[DATA_WIDTH-2:0], mosi_s};

    // A load strobe landing on a shifter load goes straight to the wire.
    always_comb begin
        tx_fill = TX_IDLE;
        if (tx_load) begin
            tx_fill = tx_data;
        end else if (!tx_empty) begin
            tx_fill = tx_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= cs_lvl ? S_IDLE : S_WAIT;
        end else begin
            unique case (1'b1)
                state == S_IDLE: begin
                    if (cs_fall) begin
                        state <= S_ACTIVE;
                    end else if (!cs_lvl) begin
                        state <= S_WAIT;
                    end
                end
                state == S_ACTIVE: begin
                    if (cs_rise) begin
                        state <= S_IDLE;
                    end
                end
                state == S_WAIT: begin
                    if (cs_lvl) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (enter || (active && cs_rise)) begin
            bit_cnt <= '0;
        end else if (shift_ok && sck_rise) begin
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift <= '0;
            rx_data  <= '0;
            new_data <= 1'b0;
        end else begin
            if (shift_ok && sck_rise) begin
                rx_shift <= rx_next;
            end
            if (word_done) begin
                rx_data  <= rx_next;
                new_data <= 1'b1;
            end else if (rd_ack) begin
                new_data <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '0;
            tx_buf   <= '0;
            tx_empty <= 1'b1;
        end else begin
            if (reload) begin
                tx_shift <= tx_fill;
            end else if (shift_ok && sck_fall) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (reload) begin
                tx_empty <= 1'b1;
            end else if (tx_load) begin
                tx_empty <= 1'b0;
            end
            if (tx_load) begin
                tx_buf <= tx_data;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (word_done && new_data && !rd_ack) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

    assign miso    = tx_shift[DATA_WIDTH-1];
    assign miso_oe = active;
    assign busy    = active;

endmodule
